ring_stop: RTL and testbench
============================

Name: ring_stop

Overview:
- Mesh-side endpoint that drives the mesh modport of one tile_if and joins that tile to a unidirectional ring of stops.
- Injects the tile's send words onto the ring toward the downstream stop.
- Ejects ring words addressed to this node into a local FIFO that feeds the tile's recv side.
- Forwards all other ring traffic to the next stop unchanged.

Parameters:
- NODE_ID, 0: ring address of this stop.
- ID_W, 4: destination field width; dest = word[31 -: ID_W].
- FIFO_DEPTH, 4: eject FIFO entries; power of two, >=2.
- STARVE_MAX, 8: consecutive blocked-injection cycles before injection takes priority over through traffic.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- send_data, in, 32 (word): tile's outgoing word.
- send_ready, in, 1: tile has a word to send; held with send_data stable until send_done.
- send_done, out, 1: one-cycle pulse, word accepted.
- recv_data, out, 32: head of the eject FIFO.
- recv_valid, out, 1: eject FIFO not empty.
- recv_ready, in, 1: tile consumes recv_data this cycle.
- link_in_data, in, 32: word from the upstream stop.
- link_in_valid, in, 1: upstream word valid.
- link_in_ready, out, 1: this stop accepts link_in_data this cycle.
- link_out_data, out, 32: registered word to the downstream stop.
- link_out_valid, out, 1: link_out_data valid.
- link_out_ready, in, 1: downstream accepts.

Behaviour:
- Reset: link_out_valid=0, link_out_data=0, send_done=0, FIFO empty (recv_valid=0, recv_data=0), starve counter=0. Reset mid-transfer drops any held out word and all FIFO contents; the tile must re-present an unacknowledged word.
- out_free = !link_out_valid || link_out_ready. A link transfer occurs when link_out_valid && link_out_ready.
- Inbound word, eject case (link_in_valid and dest==NODE_ID):
  - link_in_ready = !fifo_full.
  - Push on link_in_valid && link_in_ready.
  - Pop and push in the same cycle while full is not allowed; ready is based on full only.
- Inbound word, forward case (dest!=NODE_ID):
  - link_in_ready = out_free && !inj_priority.
  - On accept, load the out register the same edge, giving 1-cycle latency to link_out_valid.
- Injection:
  - inj_ok = send_ready && !send_done && out_free && !(forward accept this cycle).
  - On inj_ok, load the out register with send_data.
  - send_done=1 on the following cycle only; it is a registered pulse.
  - Injection is blocked in the cycle send_done is high, which prevents double capture.
- Self-addressed words:
  - Injected words are never ejected locally.
  - A word whose dest is this stop travels the full ring and ejects on return.
  - With a 1-node ring, link_out connects to link_in.
- Starvation:
  - Counter increments each cycle send_ready && !send_done && !inj_ok.
  - Counter clears on inj_ok.
  - Counter saturates at STARVE_MAX.
  - inj_priority = (count==STARVE_MAX). It deasserts forward-case link_in_ready, so injection wins the next out_free cycle.
  - Eject-case traffic is unaffected.
- Eject FIFO:
  - recv_valid = !empty; recv_data = head, which is 0 when empty.
  - Pop on recv_valid && recv_ready.
  - Push-to-recv_valid latency is 1 cycle.
  - Simultaneous push and pop when not full or empty: occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit.
- Ordering:
  - Ring words pass in arrival order.
  - Ejected words reach the tile in arrival order.
- link_out_data holds stable while link_out_valid && !link_out_ready.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, link_in_ready=1.
- NODE_ID=2: inject send_data=0x3000_00AB with link_out_ready=1 -> link_out_valid=1 with 0x3000_00AB next cycle; send_done pulses once for 1 cycle.
- link_in 0x2000_0001..0x2000_0005 back-to-back, recv_ready=0, FIFO_DEPTH=4 -> 4 accepted, link_in_ready=0 on the 5th. Then raise recv_ready -> words 1..5 delivered in order.
- Continuous forward traffic (dest=5) with send_ready held -> after 8 blocked cycles, link_in_ready drops; the injected word is sent next; counter returns to 0.
- link_out_ready=0 for 3 cycles with a forward word held -> link_out_data stable, link_in_ready=0 for forward words, an eject-addressed word is still accepted.
- Assert rst while FIFO holds 3 and the out register is valid -> next cycle recv_valid=0, link_out_valid=0, send_done=0.

Source files
------------

// File: rtl/ring_stop_if.sv
// Tile-side channel between a tile and its ring stop.
// send: the tile holds send_ready with stable send_data until send_done pulses.
// recv: recv_data is the word on offer while recv_valid is high; the tile takes it
//       in any cycle where recv_ready is also high.
interface tile_if;
    logic [31:0] send_data;
    logic        send_ready;
    logic        send_done;
    logic [31:0] recv_data;
    logic        recv_valid;
    logic        recv_ready;

    // Ring-stop side of the channel.
    modport mesh (
        input  send_data,
        input  send_ready,
        input  recv_ready,
        output send_done,
        output recv_data,
        output recv_valid
    );

    // Tile side of the channel.
    modport tile (
        output send_data,
        output send_ready,
        output recv_ready,
        input  send_done,
        input  recv_data,
        input  recv_valid
    );
endinterface

// File: rtl/ring_stop.sv
// One stop on a unidirectional ring. Words addressed to this node are ejected
// into a small FIFO for the tile; everything else is forwarded through a single
// output register. The tile's words are injected into that same register when it
// is free, with a starvation counter that eventually holds off through traffic.
//
// Link handshake: a word moves across a link in every cycle where valid and
// ready are both high; the sender keeps data stable while valid && !ready.
module ring_stop #(
    parameter int NODE_ID    = 0,
    parameter int ID_W       = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    tile_if.mesh        tile,
    input  logic [31:0] link_in_data,
    input  logic        link_in_valid,
    output logic        link_in_ready,
    output logic [31:0] link_out_data,
    output logic        link_out_valid,
    input  logic        link_out_ready,
    // Debug view of the starvation counter.
    output logic [$clog2(STARVE_MAX+1)-1:0] starve_count
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [ID_W-1:0]  NODE_ADDR = ID_W'(NODE_ID);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STARVE_MAX);

    // Eject FIFO storage; the extra pointer bit separates full from empty.
    logic [31:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        fifo_full;
    logic        fifo_empty;

    logic        send_done_q;
    logic        is_local;
    logic        out_free;
    logic        inj_priority;
    logic        fwd_accept;
    logic        push;
    logic        pop;
    logic        inj_ok;

    // Routing decisions for this cycle: eject/forward/inject arbitration.
    always_comb begin
        is_local      = (link_in_data[31 -: ID_W] == NODE_ADDR);
        fifo_empty    = (wr_ptr == rd_ptr);
        fifo_full     = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
        out_free      = !link_out_valid || link_out_ready;
        inj_priority  = (starve_count == CNT_MAX);
        // Ejects only care about FIFO space; through traffic also yields to a starved tile.
        link_in_ready = is_local ? !fifo_full : (out_free && !inj_priority);
        fwd_accept    = link_in_valid && link_in_ready && !is_local;
        push          = link_in_valid && link_in_ready && is_local;
        pop           = !fifo_empty && tile.recv_ready;
        // The send_done cycle is excluded so a still-held word is not captured twice.
        inj_ok        = tile.send_ready && !send_done_q && out_free && !fwd_accept;
    end

    // Output register: forwarded words first, then tile injections.
    always_ff @(posedge clk) begin
        if (rst) begin
            link_out_valid <= 1'b0;
            link_out_data  <= '0;
        end else if (fwd_accept) begin
            link_out_valid <= 1'b1;
            link_out_data  <= link_in_data;
        end else if (inj_ok) begin
            link_out_valid <= 1'b1;
            link_out_data  <= tile.send_data;
        end else if (link_out_ready) begin
            link_out_valid <= 1'b0;
        end
    end

    // One-cycle acknowledge to the tile after its word was captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            send_done_q <= 1'b0;
        end else begin
            send_done_q <= inj_ok;
        end
    end

    // Count cycles the tile waited without getting onto the ring, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_count <= '0;
        end else if (inj_ok) begin
            starve_count <= '0;
        end else if (tile.send_ready && !send_done_q && !inj_priority) begin
            starve_count <= starve_count + 1'b1;
        end
    end

    // FIFO pointers; a push is never issued while full, so push+pop is always safe.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage write; contents need no reset because the head is masked when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= link_in_data;
        end
    end

    // Tile-facing outputs.
    always_comb begin
        tile.send_done  = send_done_q;
        tile.recv_valid = !fifo_empty;
        tile.recv_data  = fifo_empty ? 32'd0 : mem[rd_ptr[AW-1:0]];
    end
endmodule

// File: tb/tb_ring_stop.sv
// Bench for ring_stop (NODE_ID=2, FIFO_DEPTH=4, STARVE_MAX=8): directed stimulus,
// a queue-based reference model checked every cycle, and literal spot checks.
module tb_ring_stop;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] link_in_data;
    logic        link_in_valid;
    logic        link_in_ready;
    logic [31:0] link_out_data;
    logic        link_out_valid;
    logic        link_out_ready;
    logic [3:0]  starve_count;

    tile_if t ();

    ring_stop #(
        .NODE_ID   (2),
        .ID_W      (4),
        .FIFO_DEPTH(4),
        .STARVE_MAX(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tile          (t.mesh),
        .link_in_data  (link_in_data),
        .link_in_valid (link_in_valid),
        .link_in_ready (link_in_ready),
        .link_out_data (link_out_data),
        .link_out_valid(link_out_valid),
        .link_out_ready(link_out_ready),
        .starve_count  (starve_count)
    );

    // Clock.
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Words the tile is expected to receive, in order.
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver step: inputs change just after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: the out register as a (valid, word) pair, the FIFO as a queue.
    logic [31:0] m_q[$];
    bit          m_ov = 1'b0;
    logic [31:0] m_od = '0;
    bit          m_done = 1'b0;
    int          m_cnt = 0;

    bit          e_loc, e_free, e_lir, e_rv, e_fwd, e_push, e_pop, e_inj;
    logic [31:0] e_rd;

    // Compare against the model on every falling edge, then advance the model.
    always @(negedge clk) begin
        if (chk_en) begin
            e_loc  = (link_in_data[31:28] == 4'd2);
            e_free = !m_ov || link_out_ready;
            e_lir  = e_loc ? (m_q.size() < 4) : (e_free && m_cnt != 8);
            e_rv   = (m_q.size() != 0);
            e_rd   = '0;
            if (e_rv) e_rd = m_q[0];

            chk("link_in_ready", {31'd0, link_in_ready}, {31'd0, e_lir});
            chk("link_out_valid", {31'd0, link_out_valid}, {31'd0, m_ov});
            chk("link_out_data", link_out_data, m_od);
            chk("send_done", {31'd0, t.send_done}, {31'd0, m_done});
            chk("recv_valid", {31'd0, t.recv_valid}, {31'd0, e_rv});
            chk("recv_data", t.recv_data, e_rd);
            chk("starve_count", {28'd0, starve_count}, m_cnt);

            // Scoreboard: delivered words against the hand-written order.
            if (t.recv_valid && t.recv_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    chk("recv_unexpected", t.recv_data, 32'hxxxx_xxxx);
                end else begin
                    chk("recv_order", t.recv_data, exp_q.pop_front());
                end
            end

            if (rst) begin
                m_q.delete();
                m_ov = 1'b0;
                m_od = '0;
                m_done = 1'b0;
                m_cnt = 0;
            end else begin
                e_fwd  = link_in_valid && e_lir && !e_loc;
                e_push = link_in_valid && e_lir && e_loc;
                e_pop  = e_rv && t.recv_ready;
                e_inj  = t.send_ready && !m_done && e_free && !e_fwd;
                if (e_pop) void'(m_q.pop_front());
                if (e_push) m_q.push_back(link_in_data);
                if (e_fwd) begin
                    m_ov = 1'b1;
                    m_od = link_in_data;
                end else if (e_inj) begin
                    m_ov = 1'b1;
                    m_od = t.send_data;
                end else if (link_out_ready) begin
                    m_ov = 1'b0;
                end
                if (e_inj) m_cnt = 0;
                else if (t.send_ready && !m_done && m_cnt < 8) m_cnt++;
                m_done = e_inj;
            end
        end
    end

    // Inject one word and check the capture and the single send_done pulse.
    task automatic inject(input logic [31:0] w);
        t.send_data  = w;
        t.send_ready = 1'b1;
        cyc();
        @(negedge clk);
        chk("inj_out_valid", {31'd0, link_out_valid}, 32'd1);
        chk("inj_out_data", link_out_data, w);
        chk("inj_done_high", {31'd0, t.send_done}, 32'd1);
        cyc();
        t.send_ready = 1'b0;
        @(negedge clk);
        chk("inj_done_low", {31'd0, t.send_done}, 32'd0);
        chk("inj_out_drained", {31'd0, link_out_valid}, 32'd0);
        chk("inj_no_local_eject", {31'd0, t.recv_valid}, 32'd0);
    endtask

    bit acc;

    initial begin
        rst            = 1'b1;
        link_in_data   = '0;
        link_in_valid  = 1'b0;
        link_out_ready = 1'b0;
        t.send_data    = '0;
        t.send_ready   = 1'b0;
        t.recv_ready   = 1'b0;
        cyc();
        chk_en = 1'b1;
        cyc();
        rst = 1'b0;

        // Idle after reset.
        repeat (5) cyc();
        @(negedge clk);
        chk("idle_out_valid", {31'd0, link_out_valid}, 32'd0);
        chk("idle_out_data", link_out_data, 32'd0);
        chk("idle_done", {31'd0, t.send_done}, 32'd0);
        chk("idle_recv_valid", {31'd0, t.recv_valid}, 32'd0);
        chk("idle_recv_data", t.recv_data, 32'd0);
        chk("idle_in_ready", {31'd0, link_in_ready}, 32'd1);

        // Injection, including a self-addressed word that must leave on the ring.
        cyc();
        link_out_ready = 1'b1;
        inject(32'h3000_00AB);
        cyc();
        inject(32'h2000_0042);

        // Eject fill: four fit, the fifth is held off until the tile drains.
        cyc();
        exp_q = '{32'h2000_0001, 32'h2000_0002, 32'h2000_0003, 32'h2000_0004, 32'h2000_0005};
        link_in_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            link_in_data = 32'h2000_0000 + i;
            @(negedge clk);
            chk("fill_in_ready", {31'd0, link_in_ready}, (i < 5) ? 32'd1 : 32'd0);
            if (i < 5) cyc();
        end
        cyc();
        @(negedge clk);
        chk("full_head", t.recv_data, 32'h2000_0001);
        cyc();
        t.recv_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++) begin
            @(negedge clk);
            acc = link_in_ready;
            cyc();
        end
        link_in_valid = 1'b0;
        chk("word5_accepted", {31'd0, acc}, 32'd1);
        for (int k = 0; k < 30 && exp_q.size() != 0; k++) cyc();
        chk("drain_done", exp_q.size(), 32'd0);
        t.recv_ready = 1'b0;

        // Starvation under continuous forward traffic.
        cyc();
        t.send_data   = 32'h3000_0CDE;
        t.send_ready  = 1'b1;
        link_in_data  = 32'h5000_00FF;
        link_in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            @(negedge clk);
            chk("starve_count_step", {28'd0, starve_count}, i);
            chk("starve_in_ready", {31'd0, link_in_ready}, (i < 8) ? 32'd1 : 32'd0);
        end
        cyc();
        @(negedge clk);
        chk("starve_inj_data", link_out_data, 32'h3000_0CDE);
        chk("starve_inj_done", {31'd0, t.send_done}, 32'd1);
        chk("starve_cleared", {28'd0, starve_count}, 32'd0);
        cyc();
        t.send_ready  = 1'b0;
        link_in_valid = 1'b0;
        repeat (2) cyc();

        // Downstream stall with a forward word held in the out register.
        link_out_ready = 1'b0;
        link_in_data   = 32'h5000_0077;
        link_in_valid  = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_out_valid", {31'd0, link_out_valid}, 32'd1);
            chk("stall_out_data", link_out_data, 32'h5000_0077);
            chk("stall_fwd_ready", {31'd0, link_in_ready}, 32'd0);
            cyc();
        end
        for (int i = 1; i <= 3; i++) begin
            link_in_data = 32'h2000_00E0 + i;
            @(negedge clk);
            chk("stall_eject_ready", {31'd0, link_in_ready}, 32'd1);
            cyc();
        end
        link_in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_head", t.recv_data, 32'h2000_00E1);
        chk("pre_rst_out_valid", {31'd0, link_out_valid}, 32'd1);

        // Reset with FIFO holding three words and the out register full.
        cyc();
        rst = 1'b1;
        exp_q.delete();
        cyc();
        @(negedge clk);
        chk("rst_recv_valid", {31'd0, t.recv_valid}, 32'd0);
        chk("rst_recv_data", t.recv_data, 32'd0);
        chk("rst_out_valid", {31'd0, link_out_valid}, 32'd0);
        chk("rst_done", {31'd0, t.send_done}, 32'd0);
        cyc();
        rst = 1'b0;
        link_out_ready = 1'b1;
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit in case the stimulus itself stalls.
    initial begin
        #200000;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end
endmodule
